// File: rtl/vga_pkg.sv
// Shared raster-mode definitions and timing helpers for the VGA timing generator.
// Holds the standard mode bundles, the sync polarity constants and axis helpers.
package vga_pkg;

  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FP     = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BP     = 2'd3
  } region_e;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    logic         hs_pol;
    logic         vs_pol;
  } vga_mode_t;

  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  localparam vga_mode_t VGA_640x480 = '{
    h:      '{active: 640, fp: 16, sync: 96,  bp: 48},
    v:      '{active: 480, fp: 10, sync: 2,   bp: 33},
    hs_pol: POL_NEG,
    vs_pol: POL_NEG
  };

  localparam vga_mode_t SVGA_800x600 = '{
    h:      '{active: 800, fp: 40, sync: 128, bp: 88},
    v:      '{active: 600, fp: 1,  sync: 4,   bp: 23},
    hs_pol: POL_POS,
    vs_pol: POL_POS
  };

  function automatic int mode_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Order along either axis is active, front porch, sync, back porch.
  function automatic region_e region_of(input int pos, input int active, input int fp,
                                        input int sync);
    if (pos < active) return REG_ACTIVE;
    if (pos < active + fp) return REG_FP;
    if (pos < active + fp + sync) return REG_SYNC;
    return REG_BP;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Strobe-enabled shift register that delays the {hs, vs, active} triple so it
// lines up with a downstream pixel pipeline; the last stage is the output register.
module vga_sync_delay #(
  parameter int         DEPTH   = 1,
  parameter logic [2:0] RST_VAL = 3'b110
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [2:0] i_d,
  output logic [2:0] o_q
);

  logic [DEPTH-1:0][2:0] stage_q;
  logic [DEPTH-1:0][2:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (i_en) begin
      stage_d[0] = i_d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: walks pixel positions on the pixel strobe and
// emits sync, active, clamped coordinates, line/frame/animate strobes and a frame count.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int  H_ACTIVE = int'(VGA_640x480.h.active),
  parameter int  H_FP     = int'(VGA_640x480.h.fp),
  parameter int  H_SYNC   = int'(VGA_640x480.h.sync),
  parameter int  H_BP     = int'(VGA_640x480.h.bp),
  parameter int  V_ACTIVE = int'(VGA_640x480.v.active),
  parameter int  V_FP     = int'(VGA_640x480.v.fp),
  parameter int  V_SYNC   = int'(VGA_640x480.v.sync),
  parameter int  V_BP     = int'(VGA_640x480.v.bp),
  parameter bit  HS_POL   = VGA_640x480.hs_pol,
  parameter bit  VS_POL   = VGA_640x480.vs_pol,
  parameter int  PIPE_DLY = 0,
  parameter int  FRAME_W  = 16,
  localparam int XW       = $clog2(H_ACTIVE),
  localparam int YW       = $clog2(V_ACTIVE)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_stb,
  input  logic               i_restart,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_active,
  output logic [XW-1:0]      o_x,
  output logic [YW-1:0]      o_y,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic               o_animate,
  output logic [FRAME_W-1:0] o_frame
);

  localparam int H_TOTAL = mode_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = mode_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0]    H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]    V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]    V_ANIM    = VW'(V_ACTIVE);
  localparam logic [XW-1:0]    X_MAX     = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]    Y_MAX     = YW'(V_ACTIVE - 1);
  localparam logic [2:0]       SYNC_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  if (H_ACTIVE < 2 || V_ACTIVE < 2) begin : g_chk_active
    $error("vga_timing_gen: H_ACTIVE and V_ACTIVE must be at least 2");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_porch
    $error("vga_timing_gen: every porch and sync width must be at least 1");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_chk_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..15");
  end
  if (FRAME_W < 1) begin : g_chk_frame
    $error("vga_timing_gen: FRAME_W must be at least 1");
  end

  logic [HW-1:0]      h_cnt_q, h_cnt_d;
  logic [VW-1:0]      v_cnt_q, v_cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               animate_q, animate_d;

  region_e            h_reg, v_reg;
  logic               hs_raw, vs_raw, act_raw;
  logic [2:0]         sync_raw, sync_dly;

  always_comb begin
    h_reg    = region_of(int'(h_cnt_q), H_ACTIVE, H_FP, H_SYNC);
    v_reg    = region_of(int'(v_cnt_q), V_ACTIVE, V_FP, V_SYNC);
    hs_raw   = (h_reg == REG_SYNC) ? HS_POL : ~HS_POL;
    vs_raw   = (v_reg == REG_SYNC) ? VS_POL : ~VS_POL;
    act_raw  = (h_reg == REG_ACTIVE) && (v_reg == REG_ACTIVE);
    sync_raw = {hs_raw, vs_raw, act_raw};
  end

  // The counter holds the position that the next strobe presents; pulses last one i_clk.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_d       = frame_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    animate_d     = 1'b0;
    if (i_pix_stb) begin
      x_d           = (h_reg == REG_ACTIVE) ? h_cnt_q[XW-1:0] : X_MAX;
      y_d           = (v_reg == REG_ACTIVE) ? v_cnt_q[YW-1:0] : Y_MAX;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      animate_d     = (h_cnt_q == '0) && (v_cnt_q == V_ANIM);
      if (i_restart) begin
        h_cnt_d = '0;
        v_cnt_d = '0;
      end else if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
          frame_d = frame_q + FRAME_W'(1);
        end else begin
          v_cnt_d = v_cnt_q + VW'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      animate_q     <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_q       <= frame_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      animate_q     <= animate_d;
    end
  end

  // One register aligns sync with o_x/o_y; PIPE_DLY more stages trail it by that many strobes.
  vga_sync_delay #(
    .DEPTH   (PIPE_DLY + 1),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_pix_stb),
    .i_d     (sync_raw),
    .o_q     (sync_dly)
  );

  assign o_hs          = sync_dly[2];
  assign o_vs          = sync_dly[1];
  assign o_active      = sync_dly[0];
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_animate     = animate_q;
  assign o_frame       = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small 8/2/2/2 x 4/1/1/1 mode, undelayed and PIPE_DLY=3 copies.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2, HT = HA + HF + HSW + HB;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1, VT = VA + VF + VSW + VB;
  localparam logic [14:0] RST_VEC = {3'd0, 2'd0, 3'b110, 3'b000, 4'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stb = 1'b0;
  logic rs = 1'b0;

  logic [2:0] x0, x1;
  logic [1:0] y0, y1;
  logic hs0, vs0, ac0, ls0, fs0, an0;
  logic hs1, vs1, ac1, ls1, fs1, an1;
  logic [3:0] fr0, fr1;
  logic [14:0] v0, v1;

  assign v0 = {x0, y0, hs0, vs0, ac0, ls0, fs0, an0, fr0};
  assign v1 = {x1, y1, hs1, vs1, ac1, ls1, fs1, an1, fr1};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0), .FRAME_W(4)
  ) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_restart(rs),
    .o_hs(hs0), .o_vs(vs0), .o_active(ac0), .o_x(x0), .o_y(y0),
    .o_line_start(ls0), .o_frame_start(fs0), .o_animate(an0), .o_frame(fr0)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3), .FRAME_W(4)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_restart(rs),
    .o_hs(hs1), .o_vs(vs1), .o_active(ac1), .o_x(x1), .o_y(y1),
    .o_line_start(ls1), .o_frame_start(fs1), .o_animate(an1), .o_frame(fr1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: next raster position, frame count, last presented values.
  int mh, mv, mfr;
  logic [2:0] ex;
  logic [1:0] ey;
  logic els, efs, ean;
  logic [2:0] raw_q[$];

  function automatic logic [2:0] raw_of(input int h, input int v);
    logic hs, vs, ac;
    hs = (h >= HA + HF && h < HA + HF + HSW) ? 1'b0 : 1'b1;
    vs = (v >= VA + VF && v < VA + VF + VSW) ? 1'b0 : 1'b1;
    ac = (h < HA) && (v < VA);
    return {hs, vs, ac};
  endfunction

  function automatic logic [2:0] dly_exp(input int d);
    if (raw_q.size() > d) return raw_q[raw_q.size() - 1 - d];
    return 3'b110;
  endfunction

  function automatic logic [14:0] exp_vec(input int d);
    logic [2:0] s;
    s = dly_exp(d);
    return {ex, ey, s, els, efs, ean, 4'(mfr)};
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mfr = 0;
    ex = '0; ey = '0; els = 1'b0; efs = 1'b0; ean = 1'b0;
    raw_q.delete();
  endtask

  task automatic model_strobe(input bit r_in);
    ex  = (mh < HA) ? 3'(mh) : 3'(HA - 1);
    ey  = (mv < VA) ? 2'(mv) : 2'(VA - 1);
    els = (mh == 0);
    efs = (mh == 0) && (mv == 0);
    ean = (mh == 0) && (mv == VA);
    raw_q.push_back(raw_of(mh, mv));
    if (raw_q.size() > 8) void'(raw_q.pop_front());
    if (r_in) begin
      mh = 0; mv = 0;
    end else begin
      mh++;
      if (mh == HT) begin
        mh = 0; mv++;
        if (mv == VT) begin
          mv = 0; mfr = (mfr + 1) % 16;
        end
      end
    end
  endtask

  task automatic tick(input bit s_in, input bit r_in);
    stb = s_in; rs = r_in;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (s_in) model_strobe(r_in);
      else begin els = 1'b0; efs = 1'b0; ean = 1'b0; end
    end
    #1;
    stb = 1'b0; rs = 1'b0;
  endtask

  task automatic apply_reset();
    #2; rst_n = 1'b0;
    #2; model_reset(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stb = 1'b0; rs = 1'b0;
    model_reset();
    #12;
    total++; if (v0 !== RST_VEC) begin bad++; $display("FAIL reset_dut0 got=%h exp=%h", v0, RST_VEC); end
    total++; if (v1 !== RST_VEC) begin bad++; $display("FAIL reset_dut1 got=%h exp=%h", v1, RST_VEC); end
    tick(1, 0); tick(1, 0);
    total++; if (v0 !== RST_VEC) begin bad++; $display("FAIL reset_hold_dut0 got=%h exp=%h", v0, RST_VEC); end
    @(negedge clk); rst_n = 1'b1;
    tick(1, 0);
    total++;
    if ({x0, y0, ls0, fs0, an0, ac0} !== {3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_first_strobe got=%h exp=%h", {x0, y0, ls0, fs0, an0, ac0}, {3'd0, 2'd0, 4'b1101});
    end
    total++; if (v1 !== exp_vec(3)) begin bad++; $display("FAIL reset_first_dut1 got=%h exp=%h", v1, exp_vec(3)); end
  endtask

  task automatic test_free_run();
    int last_ls, last_fs, n_hs, n_vs, n_ac;
    last_ls = -1; last_fs = -1; n_hs = 0; n_vs = 0; n_ac = 0;
    apply_reset();
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick(1, 0);
      total++; if (v0 !== exp_vec(0)) begin bad++; $display("FAIL free_dut0 cyc=%0d got=%h exp=%h", cyc, v0, exp_vec(0)); end
      total++; if (v1 !== exp_vec(3)) begin bad++; $display("FAIL free_dut1 cyc=%0d got=%h exp=%h", cyc, v1, exp_vec(3)); end
      if (ls0) begin
        if (last_ls >= 0) begin
          total++; if (cyc - last_ls != HT) begin bad++; $display("FAIL line_period got=%0d exp=%0d", cyc - last_ls, HT); end
        end
        last_ls = cyc;
      end
      if (fs0) begin
        if (last_fs >= 0) begin
          total++; if (cyc - last_fs != HT * VT) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", cyc - last_fs, HT * VT); end
        end
        last_fs = cyc;
      end
      if (!hs0) n_hs++;
      if (!vs0) n_vs++;
      if (ac0) n_ac++;
    end
    total++; if (n_hs != 2 * HSW * VT) begin bad++; $display("FAIL hs_low_count got=%0d exp=%0d", n_hs, 2 * HSW * VT); end
    total++; if (n_vs != 2 * VSW * HT) begin bad++; $display("FAIL vs_low_count got=%0d exp=%0d", n_vs, 2 * VSW * HT); end
    total++; if (n_ac != 2 * HA * VA) begin bad++; $display("FAIL active_count got=%0d exp=%0d", n_ac, 2 * HA * VA); end
  endtask

  task automatic test_slow_strobe();
    int last_chg, n_gap;
    logic [3:0] prev_fr;
    last_chg = -1; n_gap = 0; prev_fr = 4'd0;
    apply_reset();
    for (int i = 0; i < 4 * HT * VT * 2 + 40; i++) begin
      tick((i % 4) == 0, 0);
      total++; if (v0 !== exp_vec(0)) begin bad++; $display("FAIL slow_dut0 cyc=%0d got=%h exp=%h", cyc, v0, exp_vec(0)); end
      total++; if (v1 !== exp_vec(3)) begin bad++; $display("FAIL slow_dut1 cyc=%0d got=%h exp=%h", cyc, v1, exp_vec(3)); end
      if (fr0 !== prev_fr) begin
        if (last_chg >= 0) begin
          n_gap++;
          total++; if (cyc - last_chg != 4 * HT * VT) begin bad++; $display("FAIL slow_frame_gap got=%0d exp=%0d", cyc - last_chg, 4 * HT * VT); end
        end
        last_chg = cyc;
        prev_fr = fr0;
      end
    end
    total++; if (n_gap != 1) begin bad++; $display("FAIL slow_frame_gaps_seen got=%0d exp=1", n_gap); end
  endtask

  task automatic test_pipe_delay();
    int first_act1, fall0, fall1;
    first_act1 = -1; fall0 = -1; fall1 = -1;
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      tick(1, 0);
      total++; if (v1 !== exp_vec(3)) begin bad++; $display("FAIL dly_dut1 cyc=%0d got=%h exp=%h", cyc, v1, exp_vec(3)); end
      if (ac1 && first_act1 < 0) first_act1 = i;
      if (!hs0 && fall0 < 0) fall0 = i;
      if (!hs1 && fall1 < 0) fall1 = i;
    end
    total++; if (first_act1 != 4) begin bad++; $display("FAIL dly_active_rise got=%0d exp=4", first_act1); end
    total++; if (fall0 != HA + HF + 1) begin bad++; $display("FAIL hs_fall_dly0 got=%0d exp=%0d", fall0, HA + HF + 1); end
    total++; if (fall1 - fall0 != 3) begin bad++; $display("FAIL hs_fall_shift got=%0d exp=3", fall1 - fall0); end
  endtask

  task automatic test_restart();
    int n;
    apply_reset();
    n = 0;
    while (!(mh == 5 && mv == 2) && n < HT * VT) begin tick(1, 0); n++; end
    total++; if (n >= HT * VT) begin bad++; $display("FAIL restart_seek got=%0d exp=<%0d", n, HT * VT); end
    tick(1, 1);
    total++; if ({x0, y0} !== {3'd5, 2'd2}) begin bad++; $display("FAIL restart_at got=%h exp=%h", {x0, y0}, {3'd5, 2'd2}); end
    tick(1, 0);
    total++;
    if ({x0, y0, ls0, fs0, fr0} !== {3'd0, 2'd0, 1'b1, 1'b1, 4'd0}) begin
      bad++; $display("FAIL restart_next got=%h exp=%h", {x0, y0, ls0, fs0, fr0}, {3'd0, 2'd0, 1'b1, 1'b1, 4'd0});
    end
    total++; if (v1 !== exp_vec(3)) begin bad++; $display("FAIL restart_dut1 got=%h exp=%h", v1, exp_vec(3)); end
    n = 0;
    while (!(mh == HT - 1 && mv == VT - 1) && n < HT * VT) begin tick(1, 0); n++; end
    total++; if (n >= HT * VT) begin bad++; $display("FAIL restart_wrap_seek got=%0d exp=<%0d", n, HT * VT); end
    tick(1, 1);
    total++; if ({x0, y0, fr0} !== {3'd7, 2'd3, 4'd0}) begin bad++; $display("FAIL restart_wrap_at got=%h exp=%h", {x0, y0, fr0}, {3'd7, 2'd3, 4'd0}); end
    tick(1, 0);
    total++;
    if ({x0, y0, fs0, fr0} !== {3'd0, 2'd0, 1'b1, 4'd0}) begin
      bad++; $display("FAIL restart_wrap_next got=%h exp=%h", {x0, y0, fs0, fr0}, {3'd0, 2'd0, 1'b1, 4'd0});
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 2 * HT + 5; i++) tick(1, 0);
    #3; rst_n = 1'b0;
    #1; model_reset();
    total++; if (v0 !== RST_VEC) begin bad++; $display("FAIL midrst_dut0 got=%h exp=%h", v0, RST_VEC); end
    total++; if (v1 !== RST_VEC) begin bad++; $display("FAIL midrst_dut1 got=%h exp=%h", v1, RST_VEC); end
    for (int i = 0; i < 3; i++) begin
      tick(1, i == 1);
      total++; if (v0 !== RST_VEC) begin bad++; $display("FAIL midrst_hold_dut0 got=%h exp=%h", v0, RST_VEC); end
      total++; if (v1 !== RST_VEC) begin bad++; $display("FAIL midrst_hold_dut1 got=%h exp=%h", v1, RST_VEC); end
    end
    #3; rst_n = 1'b1;
    tick(1, 0);
    total++;
    if ({x0, y0, ls0, fs0} !== {3'd0, 2'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL midrst_first got=%h exp=%h", {x0, y0, ls0, fs0}, {3'd0, 2'd0, 1'b1, 1'b1});
    end
    total++; if (v1 !== exp_vec(3)) begin bad++; $display("FAIL midrst_first_dut1 got=%h exp=%h", v1, exp_vec(3)); end
  endtask

  task automatic test_clamp_animate();
    int n_an;
    n_an = 0;
    apply_reset();
    for (int i = 0; i < HT * VT; i++) begin
      tick(1, 0);
      if (an0) begin
        n_an++;
        total++; if ({x0, y0} !== {3'd0, 2'd3}) begin bad++; $display("FAIL animate_pos got=%h exp=%h", {x0, y0}, {3'd0, 2'd3}); end
      end
      if (i % HT == HT - 1) begin
        total++; if (x0 !== 3'd7) begin bad++; $display("FAIL clamp_x got=%0d exp=7", x0); end
      end
      if (i / HT >= VA) begin
        total++; if (y0 !== 2'd3) begin bad++; $display("FAIL clamp_y got=%0d exp=3", y0); end
      end
    end
    total++; if (n_an != 1) begin bad++; $display("FAIL animate_count got=%0d exp=1", n_an); end
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    for (int i = 0; i < 17 * HT * VT; i++) begin
      tick(1, 0);
      total++; if (v0 !== exp_vec(0)) begin bad++; $display("FAIL wrap_dut0 cyc=%0d got=%h exp=%h", cyc, v0, exp_vec(0)); end
    end
    total++; if ({fr0, fr1} !== {4'd1, 4'd1}) begin bad++; $display("FAIL frame_mod got=%h exp=%h", {fr0, fr1}, 8'h11); end
  endtask

  task automatic test_random();
    bit s, r;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      s = 1'($urandom_range(0, 1));
      r = s && ($urandom_range(0, 39) == 0);
      tick(s, r);
      total++; if (v0 !== exp_vec(0)) begin bad++; $display("FAIL rand_dut0 cyc=%0d got=%h exp=%h", cyc, v0, exp_vec(0)); end
      total++; if (v1 !== exp_vec(3)) begin bad++; $display("FAIL rand_dut1 cyc=%0d got=%h exp=%h", cyc, v1, exp_vec(3)); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_slow_strobe();
    test_pipe_delay();
    test_restart();
    test_reset_mid();
    test_clamp_animate();
    test_frame_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time=%0t exp=finish before limit", $time);
    $fatal(1);
  end

endmodule
